// File: rtl/image_ram_mc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// img_mem_pkg : shared types and helpers for the multi-channel image RAM
// Revision    : 1.0
// ---------------------------------------------------------------------------
package img_mem_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  function automatic bit read_lat_legal(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

  function automatic int word_width(input int num_ch, input int data_width);
    return num_ch * data_width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/image_ram_mc_sdp_array.sv
`default_nettype none
// ---------------------------------------------------------------------------
// img_sdp_array : simple dual-port array, per-channel write enable,
//                 registered read port (latency 1)
// Revision      : 1.0
// ---------------------------------------------------------------------------
module img_sdp_array
  import img_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 1,
  parameter int ADDR_WIDTH = 18,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      we,
  input  logic [NUM_CH-1:0]                         wmask,
  input  logic [ADDR_WIDTH-1:0]                     waddr,
  input  logic [word_width(NUM_CH, DATA_WIDTH)-1:0] wdata,
  input  logic                                      re,
  input  logic [ADDR_WIDTH-1:0]                     raddr,
  output logic [word_width(NUM_CH, DATA_WIDTH)-1:0] rdata
);

  localparam int WORD_W = word_width(NUM_CH, DATA_WIDTH);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rdata_d, rdata_q;

  // Read-before-write: same-address bypass is resolved by the caller.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wmask[i]) begin
          mem[waddr][i*DATA_WIDTH +: DATA_WIDTH] <= wdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[raddr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/image_ram_mc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// image_ram_mc : multi-channel image RAM with zero-fill engine, write-first
//                bypass, range checking and 1- or 2-cycle read latency
// Revision     : 1.0
// ---------------------------------------------------------------------------
module image_ram_mc
  import img_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 18,
  parameter int NUM_CH         = 1,
  parameter int DEPTH          = 2**ADDR_WIDTH,
  parameter int READ_LAT       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                           clk,
  input  logic                           initial_reset,
  input  logic                           clear,
  input  logic                           w_en,
  input  logic [NUM_CH-1:0]              w_mask,
  input  logic [ADDR_WIDTH-1:0]          w_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   data_in,
  input  logic                           r_en,
  input  logic [ADDR_WIDTH-1:0]          r_addr,
  output logic [NUM_CH*DATA_WIDTH-1:0]   data_out,
  output logic                           r_valid,
  output logic                           busy,
  output logic                           done,
  output logic                           addr_err
);

  localparam int WORD_W = word_width(NUM_CH, DATA_WIDTH);
  localparam int CW     = ADDR_WIDTH + 1;
  localparam int LAT    = read_lat_legal(READ_LAT) ? READ_LAT : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_C  = CW'(DEPTH - 1);
  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  state_t            state_d, state_q;
  logic [CW-1:0]     cnt_d, cnt_q;
  logic              acc_w, acc_r, w_oor, r_oor, hit, done_c;
  logic [WORD_W-1:0] wbits;

  logic              arr_we, arr_re;
  logic [NUM_CH-1:0] arr_mask;
  logic [ADDR_WIDTH-1:0] arr_waddr;
  logic [WORD_W-1:0] arr_wdata, arr_rdata;

  logic              s1_valid_d, s1_valid_q, s1_oor_d, s1_oor_q, err_d, err_q;
  logic [WORD_W-1:0] s1_bmask_d, s1_bmask_q, s1_wdata_d, s1_wdata_q, merged;

  assign w_oor = {1'b0, w_addr} >= DEPTH_C;
  assign r_oor = {1'b0, r_addr} >= DEPTH_C;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_c  = 1'b0;
    acc_w   = 1'b0;
    acc_r   = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        if (cnt_q == LAST_C) begin
          done_c  = 1'b1;
          cnt_d   = '0;
          state_d = ST_READY;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        if (clear) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else begin
          acc_w = w_en;
          acc_r = r_en;
        end
      end
    endcase
  end

  always_comb begin
    wbits = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wbits[i*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{w_mask[i]}};
    end
  end

  // The zero-fill engine owns the write port while the FSM is clearing.
  always_comb begin
    arr_we    = (state_q == ST_CLEAR) || (acc_w && !w_oor);
    arr_mask  = (state_q == ST_CLEAR) ? {NUM_CH{1'b1}} : w_mask;
    arr_waddr = (state_q == ST_CLEAR) ? cnt_q[ADDR_WIDTH-1:0] : w_addr;
    arr_wdata = (state_q == ST_CLEAR) ? '0 : data_in;
    arr_re    = acc_r && !r_oor;
    hit       = acc_w && !w_oor && (w_addr == r_addr);
  end

  img_sdp_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_CH     (NUM_CH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clk   (clk),
    .rst   (initial_reset),
    .we    (arr_we),
    .wmask (arr_mask),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .re    (arr_re),
    .raddr (r_addr),
    .rdata (arr_rdata)
  );

  // Bypass info is captured only on an accepted read so data_out holds.
  always_comb begin
    s1_valid_d = acc_r;
    s1_oor_d   = s1_oor_q;
    s1_bmask_d = s1_bmask_q;
    s1_wdata_d = s1_wdata_q;
    err_d      = (acc_w && w_oor) || (acc_r && r_oor);
    if (acc_r) begin
      s1_oor_d   = r_oor;
      s1_bmask_d = hit ? wbits : '0;
      s1_wdata_d = data_in;
    end
  end

  always_ff @(posedge clk or posedge initial_reset) begin
    if (initial_reset) begin
      state_q    <= RST_STATE;
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_oor_q   <= 1'b0;
      s1_bmask_q <= '0;
      s1_wdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_oor_q   <= s1_oor_d;
      s1_bmask_q <= s1_bmask_d;
      s1_wdata_q <= s1_wdata_d;
      err_q      <= err_d;
    end
  end

  assign merged = s1_oor_q ? '0 : ((arr_rdata & ~s1_bmask_q) | (s1_wdata_q & s1_bmask_q));

  generate
    if (LAT == 2) begin : g_lat2
      logic              s2_valid_d, s2_valid_q;
      logic [WORD_W-1:0] s2_data_d, s2_data_q;

      always_comb begin
        s2_valid_d = s1_valid_q;
        s2_data_d  = s1_valid_q ? merged : s2_data_q;
      end

      always_ff @(posedge clk or posedge initial_reset) begin
        if (initial_reset) begin
          s2_valid_q <= 1'b0;
          s2_data_q  <= '0;
        end else begin
          s2_valid_q <= s2_valid_d;
          s2_data_q  <= s2_data_d;
        end
      end

      assign data_out = s2_data_q;
      assign r_valid  = s2_valid_q;
    end else begin : g_lat1
      assign data_out = merged;
      assign r_valid  = s1_valid_q;
    end
  endgenerate

  assign busy     = (state_q == ST_CLEAR);
  assign done     = done_c && !initial_reset;
  assign addr_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_image_ram_mc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_image_ram_mc : directed checks on an RGB/20-word/latency-1 instance (A)
//                   and a grey/16-word/latency-2 instance (B)
// Revision        : 1.0
// ---------------------------------------------------------------------------
module tb_image_ram_mc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_clear = 0, a_w_en = 0, a_r_en = 0;
  logic [2:0]  a_w_mask = 0;
  logic [4:0]  a_w_addr = 0, a_r_addr = 0;
  logic [23:0] a_data_in = 0, a_data_out;
  logic        a_r_valid, a_busy, a_done, a_addr_err;

  logic        b_clear = 0, b_w_en = 0, b_r_en = 0;
  logic [0:0]  b_w_mask = 0;
  logic [3:0]  b_w_addr = 0, b_r_addr = 0;
  logic [7:0]  b_data_in = 0, b_data_out;
  logic        b_r_valid, b_busy, b_done, b_addr_err;

  int checks = 0;
  int failures = 0;

  image_ram_mc #(
    .DATA_WIDTH(8), .ADDR_WIDTH(5), .NUM_CH(3), .DEPTH(20), .READ_LAT(1), .CLEAR_ON_RESET(1)
  ) dut_a (
    .clk(clk), .initial_reset(rst), .clear(a_clear), .w_en(a_w_en), .w_mask(a_w_mask),
    .w_addr(a_w_addr), .data_in(a_data_in), .r_en(a_r_en), .r_addr(a_r_addr),
    .data_out(a_data_out), .r_valid(a_r_valid), .busy(a_busy), .done(a_done),
    .addr_err(a_addr_err)
  );

  image_ram_mc #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .NUM_CH(1), .DEPTH(16), .READ_LAT(2), .CLEAR_ON_RESET(1)
  ) dut_b (
    .clk(clk), .initial_reset(rst), .clear(b_clear), .w_en(b_w_en), .w_mask(b_w_mask),
    .w_addr(b_w_addr), .data_in(b_data_in), .r_en(b_r_en), .r_addr(b_r_addr),
    .data_out(b_data_out), .r_valid(b_r_valid), .busy(b_busy), .done(b_done),
    .addr_err(b_addr_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input logic [4:0] addr, input logic [23:0] d, input logic [2:0] m);
    a_w_en = 1; a_w_addr = addr; a_data_in = d; a_w_mask = m;
    tick();
    a_w_en = 0;
  endtask

  task automatic b_write(input logic [3:0] addr, input logic [7:0] d, input logic m);
    b_w_en = 1; b_w_addr = addr; b_data_in = d; b_w_mask = m;
    tick();
    b_w_en = 0;
  endtask

  task automatic a_read(input logic [4:0] addr, output logic [23:0] d, output int lat,
                        output logic err);
    a_r_en = 1; a_r_addr = addr;
    tick();
    a_r_en = 0;
    err = a_addr_err;
    lat = 1;
    while (!a_r_valid && lat < 6) begin
      tick();
      lat++;
    end
    d = a_data_out;
  endtask

  task automatic b_read(input logic [3:0] addr, output logic [7:0] d, output int lat);
    b_r_en = 1; b_r_addr = addr;
    tick();
    b_r_en = 0;
    lat = 1;
    while (!b_r_valid && lat < 6) begin
      tick();
      lat++;
    end
    d = b_data_out;
  endtask

  // Samples both instances from the current cycle onward for 40 cycles.
  task automatic measure_fill(output int ba, output int da, output int dia,
                              output int bb, output int db, output int dib);
    ba = 0; da = 0; dia = -1; bb = 0; db = 0; dib = -1;
    for (int i = 0; i < 40; i++) begin
      if (a_busy) ba++;
      if (a_done) begin da++; dia = i; end
      if (b_busy) bb++;
      if (b_done) begin db++; dib = i; end
      tick();
    end
  endtask

  initial begin
    logic [23:0] ad;
    logic [7:0]  bd;
    logic        err;
    int          lat, ba, da, dia, bb, db, dib, bad, rv;
    logic [23:0] acc_a;
    logic [7:0]  acc_b;

    // Reset state
    tick(); tick();
    check("rst_a_busy", 32'(a_busy), 32'd1);
    check("rst_b_busy", 32'(b_busy), 32'd1);
    check("rst_a_dout", 32'(a_data_out), 32'd0);
    check("rst_outs", {28'd0, a_r_valid, a_done, a_addr_err, b_r_valid}, 32'd0);

    // Fill after reset release
    rst = 0;
    measure_fill(ba, da, dia, bb, db, dib);
    check("fill1_b_busy", 32'(bb), 32'd16);
    check("fill1_b_done_cyc", 32'(dib), 32'd15);
    check("fill1_b_done_cnt", 32'(db), 32'd1);
    check("fill1_a_busy", 32'(ba), 32'd20);
    check("fill1_a_done_cyc", 32'(dia), 32'd19);

    // Every address reads zero after the fill
    acc_a = 0; acc_b = 0; bad = 0;
    for (int i = 0; i < 20; i++) begin
      a_read(5'(i), ad, lat, err);
      acc_a |= ad;
      if (lat != 1) bad++;
    end
    for (int i = 0; i < 16; i++) begin
      b_read(4'(i), bd, lat);
      acc_b |= bd;
      if (lat != 2) bad++;
    end
    check("zero_a_all", 32'(acc_a), 32'd0);
    check("zero_b_all", 32'(acc_b), 32'd0);
    check("zero_lat_bad", 32'(bad), 32'd0);

    // Per-channel masked write, latency 1
    a_write(5'd5, 24'h112233, 3'b111);
    a_write(5'd5, 24'hAABBCC, 3'b010);
    a_read(5'd5, ad, lat, err);
    check("mask_a_data", 32'(ad), 32'h11BB33);
    check("mask_a_lat", 32'(lat), 32'd1);
    tick();
    check("rvalid_one_cycle", 32'(a_r_valid), 32'd0);
    check("dout_held", 32'(a_data_out), 32'h11BB33);

    // Same-cycle write/read, write-first with partial mask
    a_w_en = 1; a_w_addr = 5; a_data_in = 24'hDDEEFF; a_w_mask = 3'b001;
    a_r_en = 1; a_r_addr = 5;
    tick();
    a_w_en = 0; a_r_en = 0;
    check("wf_a_valid", 32'(a_r_valid), 32'd1);
    check("wf_a_data", 32'(a_data_out), 32'h11BBFF);
    a_read(5'd5, ad, lat, err);
    check("wf_a_stored", 32'(ad), 32'h11BBFF);

    // Same-cycle write/read on latency-2 instance, then masked-off write
    b_w_en = 1; b_w_addr = 7; b_data_in = 8'h5A; b_w_mask = 1'b1;
    b_r_en = 1; b_r_addr = 7;
    tick();
    b_w_en = 0; b_r_en = 0;
    check("wf_b_early", 32'(b_r_valid), 32'd0);
    tick();
    check("wf_b_valid", 32'(b_r_valid), 32'd1);
    check("wf_b_data", 32'(b_data_out), 32'h5A);
    b_write(4'd7, 8'hFF, 1'b0);
    b_read(4'd7, bd, lat);
    check("mask0_b_data", 32'(bd), 32'h5A);
    check("mask0_b_lat", 32'(lat), 32'd2);

    // Out-of-range accesses
    a_write(5'd19, 24'h010203, 3'b111);
    check("oor_ok_noerr", 32'(a_addr_err), 32'd0);
    a_write(5'd25, 24'h445566, 3'b111);
    check("oor_w_err", 32'(a_addr_err), 32'd1);
    tick();
    check("oor_w_err_end", 32'(a_addr_err), 32'd0);
    a_read(5'd25, ad, lat, err);
    check("oor_r_data", 32'(ad), 32'd0);
    check("oor_r_lat", 32'(lat), 32'd1);
    check("oor_r_err", 32'(err), 32'd1);
    a_read(5'd19, ad, lat, err);
    check("oor_neighbour", 32'(ad), 32'h010203);
    a_w_en = 1; a_w_addr = 25; a_data_in = 24'h777777; a_w_mask = 3'b111;
    a_r_en = 1; a_r_addr = 30;
    tick();
    a_w_en = 0; a_r_en = 0;
    check("oor_both_err", 32'(a_addr_err), 32'd1);
    check("oor_both_data", {7'd0, a_r_valid, a_data_out}, {8'd1, 24'd0});
    tick();
    check("oor_both_single", 32'(a_addr_err), 32'd0);

    // Clear wins over simultaneous write and read
    a_write(5'd3, 24'h123456, 3'b111);
    a_read(5'd3, ad, lat, err);
    check("clr_pre", 32'(ad), 32'h123456);
    a_clear = 1; a_w_en = 1; a_w_addr = 3; a_data_in = 24'h777777; a_w_mask = 3'b111;
    a_r_en = 1; a_r_addr = 3;
    tick();
    a_clear = 0; a_w_en = 0;
    ba = 0; da = 0; rv = 0;
    for (int i = 0; i < 60; i++) begin
      if (a_r_valid) rv++;
      if (a_done) da++;
      if (!a_busy) break;
      ba++;
      tick();
    end
    a_r_en = 0;
    check("clr_busy", 32'(ba), 32'd20);
    check("clr_done", 32'(da), 32'd1);
    check("clr_no_rvalid", 32'(rv), 32'd0);
    a_read(5'd3, ad, lat, err);
    check("clr_addr3", 32'(ad), 32'd0);
    a_read(5'd5, ad, lat, err);
    check("clr_addr5", 32'(ad), 32'd0);

    // Reset mid-fill
    a_write(5'd1, 24'hABCDEF, 3'b111);
    a_read(5'd1, ad, lat, err);
    check("pre_rst_a", 32'(ad), 32'hABCDEF);
    b_clear = 1;
    tick();
    b_clear = 0;
    repeat (8) tick();
    check("midfill_busy", 32'(b_busy), 32'd1);
    rst = 1;
    #1;
    check("midrst_a_dout", 32'(a_data_out), 32'd0);
    check("midrst_b_dout", 32'(b_data_out), 32'd0);
    check("midrst_busy", {30'd0, a_busy, b_busy}, 32'd3);
    tick(); tick();
    rst = 0;
    measure_fill(ba, da, dia, bb, db, dib);
    check("fill2_b_busy", 32'(bb), 32'd16);
    check("fill2_b_done_cyc", 32'(dib), 32'd15);
    check("fill2_a_done_cyc", 32'(dia), 32'd19);
    b_read(4'd7, bd, lat);
    check("fill2_b_addr7", 32'(bd), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/image_ram_mc.md
Name: image_ram_mc

Overview:
Parametrised multi-channel image memory for the convolution datapath. It replaces the single-port 8-bit pixel RAM with a simple dual-port array: one write port and one read port per cycle, NUM_CH channels packed per word, per-channel write mask, and configurable read latency. A built-in zero-fill engine clears the array after reset or on request, and signals completion on done.

Parameters:
DATA_WIDTH, 8, bits per channel sample
ADDR_WIDTH, 18, address width (262144-pixel frame)
NUM_CH, 1, channels per word (1 = grey, 3 = RGB)
DEPTH, 2**ADDR_WIDTH, implemented words, 1..2**ADDR_WIDTH
READ_LAT, 1, read latency in cycles; legal values are 1 or 2
CLEAR_ON_RESET, 1, 1 = zero-fill runs automatically after reset release

Ports:
clk  in  1  clock, rising edge
initial_reset  in  1  asynchronous, active-high reset
clear  in  1  one-cycle pulse; starts a zero-fill
w_en  in  1  write strobe
w_mask  in  NUM_CH  per-channel write enable; bit i covers data_in[i*DATA_WIDTH +: DATA_WIDTH]
w_addr  in  ADDR_WIDTH  write address
data_in  in  NUM_CH*DATA_WIDTH  write data
r_en  in  1  read strobe
r_addr  in  ADDR_WIDTH  read address
data_out  out  NUM_CH*DATA_WIDTH  read data; held between reads
r_valid  out  1  high for exactly one cycle when data_out is updated
busy  out  1  high while zero-fill is running
done  out  1  one-cycle pulse on the last zero-fill cycle
addr_err  out  1  one-cycle pulse when an out-of-range access is accepted

Behaviour:
- Reset: async assert forces data_out=0, r_valid=0, done=0, addr_err=0, read pipeline cleared, fill counter=0.
  - FSM goes to CLEAR if CLEAR_ON_RESET=1 (busy=1 during reset), otherwise READY (busy=0).
  - Array contents are not reset asynchronously.
- FSM states: CLEAR, READY.
  - CLEAR: writes zero to address cnt each cycle, cnt increments by 1. When cnt==DEPTH-1: done=1 that cycle, next state READY, cnt returns to 0.
  - A full fill takes exactly DEPTH cycles.
  - READY -> CLEAR when clear=1 is sampled.
- In CLEAR, w_en, r_en and clear are ignored. No r_valid and no addr_err are raised.
- Simultaneous clear and w_en/r_en in READY: clear wins, and the write and read are dropped.
- Write (READY, w_en=1, w_addr<DEPTH): only channels with w_mask[i]=1 are updated. w_mask=0 means no change.
- Read (READY, r_en=1, r_addr<DEPTH): data_out and r_valid update READ_LAT cycles after the accepting edge.
  - Back-to-back reads are allowed, one per cycle, full throughput.
- Read and write to the same address in the same cycle: write-first.
  - The read returns the new data for masked-on channels and old data for masked-off channels.
- Out of range (addr >= DEPTH):
  - Write is dropped.
  - Read completes normally with data_out=0 and r_valid=1.
  - addr_err pulses one cycle after acceptance. If read and write both fault, a single pulse is raised.
- Reset asserted mid-fill or mid-read: pipeline is flushed. A fill restarts from address 0 after release if CLEAR_ON_RESET=1.
- Width rules: the counter is ADDR_WIDTH+1 bits so that DEPTH=2**ADDR_WIDTH does not wrap before the compare.

Decomposition:
- Package img_mem_pkg:
  - state enum {CLEAR, READY}
  - localparam WORD_W = NUM_CH*DATA_WIDTH
  - function for READ_LAT legality check
- One sub-module, img_sdp_array: the bare simple-dual-port array with per-channel byte-enable write and a registered read (latency 1).
- The top level adds the FSM, fill counter, write-first bypass, range check and optional second output stage.

Test Plan:
1. Reset with CLEAR_ON_RESET=1, DEPTH=16 -> busy=1 for 16 cycles after release; done pulses on cycle 16; reading all addresses then returns 0.
2. NUM_CH=3, write addr 5 data 0x112233 mask 3'b111, then addr 5 data 0xAABBCC mask 3'b010, then read addr 5 -> data_out=0x11BB33. r_valid arrives 1 cycle after r_en (READ_LAT=1) or 2 cycles after (READ_LAT=2).
3. Same cycle: write addr 7 = 0x5A mask 1 and read addr 7, with old value 0x00 -> data_out=0x5A (write-first).
4. DEPTH=20, ADDR_WIDTH=5: write addr 25 then read addr 25 -> write dropped, data_out=0, r_valid=1, addr_err pulse; read addr 19 unaffected.
5. Assert clear together with w_en to addr 3 (value 0x77) -> write dropped, busy=1 for DEPTH cycles; r_en during busy produces no r_valid; afterwards addr 3 reads 0.
6. Assert initial_reset at cnt=8 of a fill -> outputs return to 0 immediately; after release the fill restarts at 0 and done arrives 16 cycles later.
